pair_sum_stream: RTL and testbench
==================================

// Module: pair_sum_stream
// PURPOSE
//   Downstream consumer of the memory read-out stream. Takes one signed word per handshake
//   and emits the sum of the current word and the previous word.
//   A zero-valued word terminates the sequence.
//   Sits between the memory read port and the result sink/printer.
// PARAMETERS
//   DATA_W   16  width of signed input words
//   MAX_LEN  10  max nonzero words accepted per sequence before forced termination
// PORTS
//   clk        in   1            single clock, rising edge
//   rst        in   1            asynchronous, active-high reset
//   start      in   1            pulse: begin new sequence (honoured in IDLE/DONE only)
//   in_valid   in   1            input word valid
//   in_ready   out  1            input word accepted when in_valid&&in_ready
//   in_data    in   DATA_W       signed input word
//   out_valid  out  1            sum valid
//   out_ready  in   1            sink accepts sum when out_valid&&out_ready
//   out_data   out  DATA_W+1     signed sum, current + previous
//   count      out  clog2(MAX_LEN+1)  nonzero words accepted in current sequence
//   done       out  1            level: sequence finished and output drained
//   overflow   out  1            level: sequence ended by MAX_LEN, not by zero word
// BEHAVIOUR
// - Reset (async): state=IDLE; out_valid=0, out_data=0, count=0, done=0, overflow=0, prev=0.
//   in_ready is combinational and therefore 0.
// - FSM:
//   - IDLE -start-> RUN
//   - RUN -zero word accepted | MAX_LEN-th nonzero accepted-> DRAIN
//   - DRAIN -out_valid==0 (incl. same-cycle out_ready drain)-> DONE
//   - DONE -start-> RUN
//   - start in RUN/DRAIN is ignored.
// - Entering RUN clears prev, count, done and overflow.
// - in_ready = (state==RUN) && (!out_valid || out_ready). Zero in every other state.
// - Nonzero word accepted:
//   - out_data <= sext(in_data) + sext(prev), computed at full DATA_W+1 width; never overflows.
//   - out_valid <= 1, prev <= in_data, count++.
//   - Latency: 1 cycle from accept to out_valid.
//   - Full throughput (1 word/cycle) while out_ready=1.
// - Zero word accepted: consumed and produces no output. prev and count are unchanged.
// - MAX_LEN-th nonzero word: its sum is emitted, then overflow<=1 and go to DRAIN.
//   Subsequent inputs are not accepted.
// - Output hold: out_valid && !out_ready holds out_data stable.
// - out_valid clears on out_ready unless refilled in the same cycle.
// - done rises the cycle DONE is entered. It stays high until start.
// - overflow is held until start.
// - Reset mid-sequence: immediate return to reset values. A pending output is discarded.
// CONFIGURATION
// - PAIR_SUM_SKIP_FIRST_EN defined:
//   - The first nonzero word after start only primes prev and produces no output.
//   - Its count is still incremented.
//   - Outputs begin with the second word.
// - Undefined: the first word pairs with prev=0, so out_data = sext(first word).
// STRUCTURE
// - pair_sum_pkg:
//   - state enum {IDLE, RUN, DRAIN, DONE}
//   - function for sign-extended add
//   - count-width helper constant
// - One sub-module, pair_sum_out_reg: the output valid/ready holding register.
//   It is parameterised on width.
// - FSM, prev and count live in the top.
// TESTING
// 1. DATA_W=16. start; words 1,2,3,0; out_ready=1
//    -> out_data 1,3,5; count=3; done=1 after drain; overflow=0.
// 2. Same stream with out_ready=0 for 3 cycles after the first output
//    -> in_ready=0 and out_data=1 held for those cycles; full sequence 1,3,5 with no loss.
// 3. MAX_LEN=4; words 1..9 with no zero
//    -> outputs 1,3,5,7; count=4; overflow=1; in_ready=0 afterwards; done=1.
// 4. Words -32768,-32768,0 -> out_data -32768 then -65536 (17-bit); no wrap.
// 5. rst pulse after the second accepted word, with out_valid high
//    -> out_valid=0, count=0, done=0, in_ready=0 immediately; start restarts cleanly.
// 6. PAIR_SUM_SKIP_FIRST_EN defined; words 1,2,3,0 -> outputs 3,5; count=3; done=1.

Source files
------------

// File: rtl/pair_sum_pkg.sv
// Shared types and helpers for the pair-sum stream consumer.
package pair_sum_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_MAX_LEN = 10;

  // Widest word the adder helper handles; DATA_W must stay below this.
  localparam int SUM_MAX_W = 32;

  // Width of a counter able to hold 0..max_len.
  function automatic int cnt_w(input int max_len);
    return (max_len < 1) ? 1 : $clog2(max_len + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_w(DEF_MAX_LEN);

  // Sign-extend both operands by one bit before adding, so the sum can never wrap.
  function automatic logic signed [SUM_MAX_W:0] sext_add(
    input logic signed [SUM_MAX_W-1:0] a,
    input logic signed [SUM_MAX_W-1:0] b
  );
    return signed'({a[SUM_MAX_W-1], a}) + signed'({b[SUM_MAX_W-1], b});
  endfunction

endpackage

// File: rtl/pair_sum_out_reg.sv
// Output holding register with valid/ready handshake; width-parameterised.
module pair_sum_out_reg #(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         free
);

  // Register can take a new word when empty or being drained this cycle.
  assign free = !valid || ready;

  // Load wins over drain so back-to-back words keep full throughput; data holds otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pair_sum_stream.sv
// Pair-sum stream consumer: emits current + previous signed word for each nonzero input;
// a zero word or MAX_LEN nonzero words end the sequence.
// Optional build macro PAIR_SUM_SKIP_FIRST_EN: the first nonzero word only primes prev.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting words, producing sums
// DRAIN | sequence ended, waiting for last sum to leave
// DONE  | finished, done high, waiting for start
module pair_sum_stream
  import pair_sum_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int MAX_LEN = DEF_MAX_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [DATA_W-1:0]       in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [DATA_W:0]         out_data,
  output logic [cnt_w(MAX_LEN)-1:0]      count,
  output logic                           done,
  output logic                           overflow
);

  localparam int CNT_W = cnt_w(MAX_LEN);

  state_t state, state_nx;

  logic signed [DATA_W-1:0]    prev;
  logic signed [SUM_MAX_W-1:0] in_wide;
  logic signed [SUM_MAX_W-1:0] prev_wide;
  logic signed [SUM_MAX_W:0]   sum_wide;
  logic [DATA_W:0]             sum;
  logic                        unused_sum_hi;

  logic out_free;
  logic take;
  logic word_nz;
  logic take_nz;
  logic last_word;
  logic load;
  logic enter_run;
  logic finish;

  assign in_ready  = (state == RUN) && out_free;
  assign take      = in_valid && in_ready;
  assign word_nz   = (in_data != '0);
  assign take_nz   = take && word_nz;
  assign last_word = (count == CNT_W'(MAX_LEN - 1));

  assign in_wide       = SUM_MAX_W'(in_data);
  assign prev_wide     = SUM_MAX_W'(prev);
  assign sum_wide      = sext_add(in_wide, prev_wide);
  assign sum           = sum_wide[DATA_W:0];
  assign unused_sum_hi = ^sum_wide[SUM_MAX_W:DATA_W+1];

`ifdef PAIR_SUM_SKIP_FIRST_EN
  logic primed;

  // First nonzero word of a sequence only fills prev; later words produce sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      primed <= 1'b0;
    end else if (enter_run) begin
      primed <= 1'b0;
    end else if (take_nz) begin
      primed <= 1'b1;
    end
  end

  assign load = take_nz && primed;
`else
  assign load = take_nz;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state decode; start is only honoured in IDLE and DONE.
  always_comb begin
    state_nx  = state;
    enter_run = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx  = RUN;
          enter_run = 1'b1;
        end
      end
      RUN: begin
        if (take && (!word_nz || last_word)) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (out_free) begin
          state_nx = DONE;
          finish   = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          state_nx  = RUN;
          enter_run = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Sequence bookkeeping: prev, count and the done/overflow status levels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev     <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else if (enter_run) begin
      prev     <= '0;
      count    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (take_nz) begin
        prev  <= in_data;
        count <= count + CNT_W'(1);
        if (last_word) begin
          overflow <= 1'b1;
        end
      end
      if (finish) begin
        done <= 1'b1;
      end
    end
  end

  pair_sum_out_reg #(
    .W (DATA_W + 1)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (sum),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .free      (out_free)
  );

endmodule

// File: tb/tb_pair_sum_stream.sv
// Directed bench for pair_sum_stream (MAX_LEN=4 so the forced-termination case is short).
module tb_pair_sum_stream;

  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 4;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

`ifdef PAIR_SUM_SKIP_FIRST_EN
  localparam int EXP_FIRST     = 3;
  localparam int EXP_LAT_VALID = 0;
`else
  localparam int EXP_FIRST     = 1;
  localparam int EXP_LAT_VALID = 1;
`endif

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic in_valid;
  logic in_ready;
  logic signed [DATA_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic signed [DATA_W:0] out_data;
  logic [CNT_W-1:0] count;
  logic done;
  logic overflow;

  int n_checks = 0;
  int n_errors = 0;
  int accepted;
  int words[$];
  longint exp_q[$];
  longint got[$];

  always #5 clk = ~clk;

  pair_sum_stream #(
    .DATA_W  (DATA_W),
    .MAX_LEN (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .done      (done),
    .overflow  (overflow)
  );

  // Capture every output handshake away from the active edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got.push_back(longint'(out_data));
    end
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: plain, 1: check first-accept latency, 2: stall sink after first output.
  task automatic send_words(input int mode);
    int idx = 0;
    int idle = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    accepted = 0;
    while (idx < words.size() && idle < 8) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(words[idx]);
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        idx++;
        accepted++;
        idle = 0;
        if (mode == 1 && first) begin
          check("latency_valid", longint'(out_valid), EXP_LAT_VALID);
        end
        first = 1'b0;
        if (mode == 2 && !stalled && out_valid) begin
          stalled   = 1'b1;
          out_ready = 1'b0;
          in_data   = (idx < words.size()) ? DATA_W'(words[idx]) : '0;
          repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", longint'(in_ready), 0);
            check("stall_valid", longint'(out_valid), 1);
            check("stall_hold", longint'(out_data), EXP_FIRST);
            @(posedge clk); #1;
          end
          out_ready = 1'b1;
        end
      end else begin
        @(posedge clk); #1;
        idle++;
      end
    end
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    @(negedge clk);
    check(tag, longint'(done), 1);
  endtask

  task automatic compare_got(input string tag);
    check({tag, "_n"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      check($sformatf("%s_%0d", tag, i), got[i], exp_q[i]);
    end
    got.delete();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    in_valid = 1'b1;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_count", longint'(count), 0);
    check("rst_done", longint'(done), 0);
    check("rst_overflow", longint'(overflow), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready", longint'(in_ready), 0);
    in_valid = 1'b0;

    // basic stream 1,2,3,0
    pulse_start();
    words = '{1, 2, 3, 0};
    send_words(1);
    check("t1_accepted", accepted, 4);
    wait_done("t1_done");
    check("t1_count", longint'(count), 3);
    check("t1_overflow", longint'(overflow), 0);
    check("t1_in_ready", longint'(in_ready), 0);
`ifdef PAIR_SUM_SKIP_FIRST_EN
    exp_q = '{3, 5};
`else
    exp_q = '{1, 3, 5};
`endif
    compare_got("t1_out");

    // same stream with sink backpressure after the first output
    pulse_start();
    check("t2_done_clr", longint'(done), 0);
    words = '{1, 2, 3, 0};
    send_words(2);
    wait_done("t2_done");
    check("t2_count", longint'(count), 3);
`ifdef PAIR_SUM_SKIP_FIRST_EN
    exp_q = '{3, 5};
`else
    exp_q = '{1, 3, 5};
`endif
    compare_got("t2_out");

    // forced termination at MAX_LEN
    pulse_start();
    words = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    send_words(0);
    check("t3_accepted", accepted, 4);
    wait_done("t3_done");
    check("t3_count", longint'(count), 4);
    check("t3_overflow", longint'(overflow), 1);
    check("t3_in_ready", longint'(in_ready), 0);
`ifdef PAIR_SUM_SKIP_FIRST_EN
    exp_q = '{3, 5, 7};
`else
    exp_q = '{1, 3, 5, 7};
`endif
    compare_got("t3_out");

    // most negative words, sum needs the extra bit
    pulse_start();
    check("t4_overflow_clr", longint'(overflow), 0);
    words = '{-32768, -32768, 0};
    send_words(0);
    wait_done("t4_done");
    check("t4_count", longint'(count), 2);
`ifdef PAIR_SUM_SKIP_FIRST_EN
    exp_q = '{-65536};
`else
    exp_q = '{-32768, -65536};
`endif
    compare_got("t4_out");

    // reset mid-sequence with an output pending
    pulse_start();
    words = '{5, 6};
    send_words(0);
    check("t5_pre_valid", longint'(out_valid), 1);
    rst = 1'b1;
    #1;
    check("t5_out_valid", longint'(out_valid), 0);
    check("t5_count", longint'(count), 0);
    check("t5_done", longint'(done), 0);
    check("t5_in_ready", longint'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    got.delete();
    @(posedge clk); #1;
    pulse_start();
    words = '{1, 2, 3, 0};
    send_words(0);
    wait_done("t5_re_done");
    check("t5_re_count", longint'(count), 3);
`ifdef PAIR_SUM_SKIP_FIRST_EN
    exp_q = '{3, 5};
`else
    exp_q = '{1, 3, 5};
`endif
    compare_got("t5_re_out");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
